// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX->MEM pipeline register sitting after the EX-stage ALU. It also holds
//   the architectural {Z,V,N} flag register, a sticky halt bit, a forwarding
//   tap for the EX stage, and a 16-bit count of instructions that left EX.
//
// Ports
//   clk, rst_n                : clock (rising edge), async active-low reset
//   stall, flush              : hold everything / inject a bubble (flush wins)
//   ex_*                      : instruction currently in EX
//   mem_*                     : registered instruction now in MEM
//   flags                     : {Z,V,N}, updated as an instruction advances
//   fwd_en, fwd_rd, fwd_data  : forwarding tap taken from the stage registers
//   halted                    : set once HLT (4'hF) advances; cleared by reset
//   retire_cnt                : wrapping count of advanced instructions
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_ovfl,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              mem_valid,
  output logic [3:0]        mem_opcode,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_st_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [2:0]        flags,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              halted,
  output logic [15:0]       retire_cnt
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic              valid_q,  valid_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [DATA_W-1:0] st_q,     st_d;
  logic [REG_AW-1:0] rd_q,     rd_d;
  logic              rw_q,     rw_d;
  logic              mr_q,     mr_d;
  logic              mw_q,     mw_d;
  logic [2:0]        flags_q,  flags_d;   // {Z,V,N}
  logic              halted_q, halted_d;
  logic [15:0]       cnt_q,    cnt_d;

  logic res_zero;
  assign res_zero = (ex_alu_out == '0);

  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    alu_d    = alu_q;
    st_d     = st_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    // Flush is checked before stall so a flushed slot never survives a stall.
    if (flush || (!stall && (!ex_valid || halted_q))) begin
      valid_d  = 1'b0;
      opcode_d = '0;
      alu_d    = '0;
      st_d     = '0;
      rd_d     = '0;
      rw_d     = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
    end else if (!stall) begin
      valid_d  = 1'b1;
      opcode_d = ex_opcode;
      alu_d    = ex_alu_out;
      st_d     = ex_st_data;
      rd_d     = ex_rd;
      rw_d     = ex_reg_write;
      mr_d     = ex_mem_read;
      mw_d     = ex_mem_write;
      cnt_d    = cnt_q + 16'd1;
      if (ex_opcode == OP_HLT) halted_d = 1'b1;
      case (ex_opcode)
        OP_ADD, OP_SUB:                 flags_d = {res_zero, ex_ovfl, ex_alu_out[DATA_W-1]};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[2] = res_zero;
        default:                        flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      alu_q    <= '0;
      st_q     <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      flags_q  <= 3'b000;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      alu_q    <= alu_d;
      st_q     <= st_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_valid     = valid_q;
  assign mem_opcode    = opcode_q;
  assign mem_alu_out   = alu_q;
  assign mem_st_data   = st_q;
  assign mem_rd        = rd_q;
  assign mem_reg_write = rw_q & valid_q;
  assign mem_mem_read  = mr_q & valid_q;
  assign mem_mem_write = mw_q & valid_q;
  assign flags         = flags_q;
  assign halted        = halted_q;
  assign retire_cnt    = cnt_q;

  // r0 is hardwired zero, so it is never a forwarding source.
  assign fwd_en   = valid_q & rw_q & (rd_q != '0);
  assign fwd_rd   = rd_q;
  assign fwd_data = alu_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, ex_valid, ex_ovfl;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_alu_out, ex_st_data;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [3:0]  mem_opcode, mem_rd, fwd_rd;
  logic [15:0] mem_alu_out, mem_st_data, fwd_data, retire_cnt;
  logic [2:0]  flags;
  logic        fwd_en, halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
    .ex_ovfl(ex_ovfl), .ex_st_data(ex_st_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_out(mem_alu_out),
    .mem_st_data(mem_st_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .flags(flags), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .halted(halted), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [3:0]  op;
    logic [15:0] alu;
    logic        ovfl;
    logic [15:0] st;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    logic        e_mv;
    logic [3:0]  e_op;
    logic [15:0] e_alu;
    logic [3:0]  e_rd;
    logic [2:0]  e_flags;
    logic        e_fwd;
    logic [15:0] e_cnt;
    logic        e_mw;
    logic [15:0] e_st;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic [3:0] op,
                       input logic [15:0] alu, input logic ov, input logic [15:0] st,
                       input logic [3:0] rd, input logic rw, input logic mr, input logic mw);
    stall = s; flush = f; ex_valid = v; ex_opcode = op; ex_alu_out = alu;
    ex_ovfl = ov; ex_st_data = st; ex_rd = rd; ex_reg_write = rw;
    ex_mem_read = mr; ex_mem_write = mw;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //          stl flu val op    alu       ov st        rd    rw mr mw   mv op    alu       rd    flags  fwd cnt     mw st
    vecs[0]  = '{0, 0, 1, 4'h0, 16'h0000, 1, 16'h1111, 4'd1, 1, 0, 0,  1, 4'h0, 16'h0000, 4'd1, 3'b110, 1, 16'd1,  0, 16'h1111};
    vecs[1]  = '{0, 0, 1, 4'h1, 16'h8005, 0, 16'h2222, 4'd2, 1, 0, 0,  1, 4'h1, 16'h8005, 4'd2, 3'b001, 1, 16'd2,  0, 16'h2222};
    vecs[2]  = '{0, 0, 1, 4'h0, 16'h8000, 1, 16'h0000, 4'd3, 1, 0, 0,  1, 4'h0, 16'h8000, 4'd3, 3'b011, 1, 16'd3,  0, 16'h0000};
    vecs[3]  = '{0, 0, 1, 4'h2, 16'h8001, 0, 16'h0000, 4'd4, 1, 0, 0,  1, 4'h2, 16'h8001, 4'd4, 3'b011, 1, 16'd4,  0, 16'h0000};
    vecs[4]  = '{0, 0, 1, 4'h7, 16'h0000, 1, 16'h0000, 4'd5, 1, 0, 0,  1, 4'h7, 16'h0000, 4'd5, 3'b011, 1, 16'd5,  0, 16'h0000};
    vecs[5]  = '{0, 0, 1, 4'h4, 16'h0000, 0, 16'h0000, 4'd6, 1, 0, 0,  1, 4'h4, 16'h0000, 4'd6, 3'b111, 1, 16'd6,  0, 16'h0000};
    vecs[6]  = '{0, 0, 1, 4'h3, 16'h1234, 0, 16'h0000, 4'd0, 1, 0, 0,  1, 4'h3, 16'h1234, 4'd0, 3'b111, 0, 16'd7,  0, 16'h0000};
    vecs[7]  = '{0, 0, 0, 4'h0, 16'h0000, 0, 16'h7777, 4'd9, 1, 0, 0,  0, 4'h0, 16'h0000, 4'd0, 3'b111, 0, 16'd7,  0, 16'h0000};
    vecs[8]  = '{0, 1, 1, 4'h0, 16'h5555, 1, 16'h7777, 4'd9, 1, 0, 0,  0, 4'h0, 16'h0000, 4'd0, 3'b111, 0, 16'd7,  0, 16'h0000};
    vecs[9]  = '{0, 0, 1, 4'h6, 16'h0040, 1, 16'h0000, 4'd7, 1, 0, 0,  1, 4'h6, 16'h0040, 4'd7, 3'b011, 1, 16'd8,  0, 16'h0000};
    vecs[10] = '{0, 0, 1, 4'h5, 16'h0000, 0, 16'h0000, 4'd8, 0, 0, 0,  1, 4'h5, 16'h0000, 4'd8, 3'b111, 0, 16'd9,  0, 16'h0000};
    vecs[11] = '{0, 0, 1, 4'h9, 16'h0010, 0, 16'hABCD, 4'd0, 0, 0, 1,  1, 4'h9, 16'h0010, 4'd0, 3'b111, 0, 16'd10, 1, 16'hABCD};

    rst_n = 1'b0;
    drive(0, 0, 0, 4'h0, 16'h0, 0, 16'h0, 4'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset_flags", {29'd0, flags}, 32'd0);
    chk("reset_cnt", {16'd0, retire_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].op, vecs[i].alu,
            vecs[i].ovfl, vecs[i].st, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, mem_valid}, {31'd0, vecs[i].e_mv});
      chk($sformatf("v%0d_opcode", i), {28'd0, mem_opcode}, {28'd0, vecs[i].e_op});
      chk($sformatf("v%0d_alu", i), {16'd0, mem_alu_out}, {16'd0, vecs[i].e_alu});
      chk($sformatf("v%0d_rd", i), {28'd0, mem_rd}, {28'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_flags", i), {29'd0, flags}, {29'd0, vecs[i].e_flags});
      chk($sformatf("v%0d_fwd_en", i), {31'd0, fwd_en}, {31'd0, vecs[i].e_fwd});
      chk($sformatf("v%0d_cnt", i), {16'd0, retire_cnt}, {16'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_memwr", i), {31'd0, mem_mem_write}, {31'd0, vecs[i].e_mw});
      chk($sformatf("v%0d_st", i), {16'd0, mem_st_data}, {16'd0, vecs[i].e_st});
    end

    // stall three cycles with changing EX contents: SW from vecs[11] stays put
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 4'h0, 16'h0000 + 16'(i), 1'(i), 16'h4444, 4'd1 + 4'(i), 1, 0, 0);
      step();
      chk("stall_valid", {31'd0, mem_valid}, 32'd1);
      chk("stall_alu", {16'd0, mem_alu_out}, 32'h0010);
      chk("stall_memwr", {31'd0, mem_mem_write}, 32'd1);
      chk("stall_flags", {29'd0, flags}, 32'b111);
      chk("stall_cnt", {16'd0, retire_cnt}, 32'd10);
    end

    drive(1, 1, 1, 4'h0, 16'h0000, 1, 16'h4444, 4'd1, 1, 0, 0);
    step();
    chk("stallflush_valid", {31'd0, mem_valid}, 32'd0);
    chk("stallflush_alu", {16'd0, mem_alu_out}, 32'd0);
    chk("stallflush_flags", {29'd0, flags}, 32'b111);
    chk("stallflush_cnt", {16'd0, retire_cnt}, 32'd10);

    // HLT, then ADD r1 that must never be captured
    drive(0, 0, 1, 4'hF, 16'h00FF, 0, 16'h0, 4'd0, 0, 0, 0);
    step();
    chk("hlt_valid", {31'd0, mem_valid}, 32'd1);
    chk("hlt_opcode", {28'd0, mem_opcode}, 32'hF);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_cnt", {16'd0, retire_cnt}, 32'd11);
    drive(0, 0, 1, 4'h0, 16'h0000, 0, 16'h0, 4'd1, 1, 0, 0);
    step();
    chk("posthlt_valid", {31'd0, mem_valid}, 32'd0);
    chk("posthlt_halted", {31'd0, halted}, 32'd1);
    chk("posthlt_cnt", {16'd0, retire_cnt}, 32'd11);
    chk("posthlt_flags", {29'd0, flags}, 32'b111);
    chk("posthlt_fwd", {31'd0, fwd_en}, 32'd0);
    step();
    chk("posthlt2_valid", {31'd0, mem_valid}, 32'd0);

    // release halt state by reset asserted mid-stall, between clock edges
    drive(1, 0, 1, 4'h0, 16'h0000, 0, 16'h0, 4'd1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    chk("midrst_flags", {29'd0, flags}, 32'd0);
    chk("midrst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("midrst_opcode", {28'd0, mem_opcode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // one valid capture into a non-zero register, then a live reset
    drive(0, 0, 1, 4'h1, 16'h0003, 0, 16'h0, 4'd2, 1, 0, 0);
    step();
    chk("live_fwd", {31'd0, fwd_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("liverst_valid", {31'd0, mem_valid}, 32'd0);
    chk("liverst_fwd", {31'd0, fwd_en}, 32'd0);
    chk("liverst_alu", {16'd0, mem_alu_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // counter wrap: 65535 advances to FFFF, one more wraps to 0
    drive(0, 0, 1, 4'h0, 16'h0001, 0, 16'h0, 4'd0, 1, 0, 0);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("wrap_cnt_ffff", {16'd0, retire_cnt}, 32'hFFFF);
    chk("wrap_fwd_r0", {31'd0, fwd_en}, 32'd0);
    chk("wrap_regwr", {31'd0, mem_reg_write}, 32'd1);
    chk("wrap_flags", {29'd0, flags}, 32'd0);
    step();
    chk("wrap_cnt_zero", {16'd0, retire_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
